// File: rtl/product_accumulator_if.sv
// ---------------------------------------------------------------------------
// product_accumulator_if
//   Bundles the product-side and result-side handshakes of the
//   product_accumulator stage.
//   Parameters:
//     PW - product width, AW - accumulator width
//   Signals:
//     clear        synchronous abort of the current block (master -> slave)
//     in_valid     product/prod_signed are valid         (master -> slave)
//     in_ready     stage can accept a product            (slave  -> master)
//     product      multiplier result, PW bits            (master -> slave)
//     prod_signed  1: sign-extend product, 0: zero-extend (master -> slave)
//     out_valid    acc_out holds a completed block sum    (slave  -> master)
//     out_ready    consumer takes the result              (master -> slave)
//     acc_out      block sum, AW bits, two's complement   (slave  -> master)
//     overflow     sticky signed overflow of the block    (slave  -> master)
//     count        products accepted in the current block (slave  -> master)
// ---------------------------------------------------------------------------
interface product_accumulator_if #(
  parameter int PW = 16,
  parameter int AW = 24
);
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] product;
  logic          prod_signed;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] acc_out;
  logic          overflow;
  logic [7:0]    count;

  modport master (
    output clear, in_valid, product, prod_signed, out_ready,
    input  in_ready, out_valid, acc_out, overflow, count
  );

  modport slave (
    input  clear, in_valid, product, prod_signed, out_ready,
    output in_ready, out_valid, acc_out, overflow, count
  );
endinterface

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//   Sums blocks of N multiplier products into a wide two's-complement
//   accumulator and presents each block sum on a registered valid/ready
//   output. Each product is sign- or zero-extended as selected by
//   prod_signed. A sticky flag records signed overflow within the block;
//   the accumulator itself wraps.
//   Parameters:
//     PW - product width, AW - accumulator width (AW > PW),
//     N  - products per block (1..255)
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - slave side of product_accumulator_if (handshakes, clear,
//            product input, block result, overflow, count)
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int PW = 16,
  parameter int AW = 24,
  parameter int N  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [7:0] BLOCK_LEN = 8'(N);

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [AW-1:0] ext;
  logic [AW:0]   sum;
  logic          add_ovf;

  // Extend the product, then add with one guard bit: when the guard bit and
  // the AW-bit sign disagree, both operands had equal signs and the
  // truncated result flipped sign.
  always_comb begin
    ext     = bus.prod_signed ? {{(AW-PW){bus.product[PW-1]}}, bus.product}
                              : {{(AW-PW){1'b0}}, bus.product};
    sum     = {acc_q[AW-1], acc_q} + {ext[AW-1], ext};
    add_ovf = sum[AW] ^ sum[AW-1];
  end

  // Next-state logic. clear outranks everything else, including an output
  // handshake in the same cycle, which leaves the same zeroed ACC state.
  // A product is consumed only in ACC; the accept that completes the block
  // moves to DONE, where the result holds until the consumer takes it.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.clear) begin
      state_d    = ACC;
      acc_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (bus.in_valid) begin
            acc_d      = sum[AW-1:0];
            count_d    = count_q + 8'd1;
            overflow_d = overflow_q | add_ovf;
            if (count_d == BLOCK_LEN) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d    = ACC;
            acc_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  // State registers; reset discards any partial block immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACC;
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs come only from registers or the state decode.
  always_comb begin
    bus.in_ready  = (state_q == ACC);
    bus.out_valid = (state_q == DONE);
    bus.acc_out   = acc_q;
    bus.overflow  = overflow_q;
    bus.count     = count_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//   Self-checking bench for product_accumulator. The main instance
//   (PW=16, AW=24, N=4) is tracked every cycle by a behavioural model; two
//   extra instances (AW=18 and N=1) exercise overflow and single-product
//   blocks with directed, hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  product_accumulator_if #(.PW(16), .AW(24)) bus   ();
  product_accumulator_if #(.PW(16), .AW(18)) bus18 ();
  product_accumulator_if #(.PW(16), .AW(24)) bus1  ();

  product_accumulator #(.PW(16), .AW(24), .N(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  product_accumulator #(.PW(16), .AW(18), .N(4)) u_dut18 (
    .clk (clk),
    .rst (rst),
    .bus (bus18)
  );

  product_accumulator #(.PW(16), .AW(24), .N(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the main instance: the block sum is kept as a
  // signed integer, and overflow means the exact sum of the wrapped
  // accumulator and the new product leaves the 24-bit signed range.
  logic [23:0] m_acc;
  int          m_count;
  bit          m_ovf;
  bit          m_done;
  longint      m_ext;
  longint      m_full;

  always @(posedge clk or posedge rst) begin
    if (rst || bus.clear || (m_done && bus.out_ready)) begin
      m_acc   = '0;
      m_count = 0;
      m_ovf   = 1'b0;
      m_done  = 1'b0;
    end else if (!m_done && bus.in_valid) begin
      m_ext   = bus.prod_signed ? longint'($signed(bus.product))
                                : longint'(bus.product);
      m_full  = longint'($signed(m_acc)) + m_ext;
      if (m_full > 64'sd8388607 || m_full < -64'sd8388608) begin
        m_ovf = 1'b1;
      end
      m_acc   = 24'(m_full);
      m_count = m_count + 1;
      if (m_count == 4) begin
        m_done = 1'b1;
      end
    end
  end

  // Compare the main instance against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks = n_checks + 1;
      if (bus.out_valid !== m_done || bus.in_ready !== !m_done ||
          bus.acc_out !== m_acc || bus.overflow !== m_ovf ||
          bus.count !== 8'(m_count)) begin
        n_fail = n_fail + 1;
        $display("[TB] FAIL model_cmp t=%0t: got v=%b r=%b acc=%h ovf=%b cnt=%0d, expected v=%b r=%b acc=%h ovf=%b cnt=%0d",
                 $time, bus.out_valid, bus.in_ready, bus.acc_out, bus.overflow, bus.count,
                 m_done, !m_done, m_acc, m_ovf, m_count);
      end
    end
  end

  // Drive the main instance's inputs at a falling edge.
  task automatic applyStimulus(input logic [15:0] p, input logic s,
                               input logic v, input logic r, input logic c);
    @(negedge clk);
    bus.product     = p;
    bus.prod_signed = s;
    bus.in_valid    = v;
    bus.out_ready   = r;
    bus.clear       = c;
  endtask

  // Single value comparison against a hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // All observable outputs of the main instance at once.
  task automatic checkMain(input string name, input logic v, input logic [23:0] acc,
                           input logic ovf, input logic [7:0] cnt);
    checkOutput({name, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    checkOutput({name, ".in_ready"},  32'(bus.in_ready),  32'(!v));
    checkOutput({name, ".acc_out"},   32'(bus.acc_out),   32'(acc));
    checkOutput({name, ".overflow"},  32'(bus.overflow),  32'(ovf));
    checkOutput({name, ".count"},     32'(bus.count),     32'(cnt));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.clear = 1'b0;   bus.in_valid = 1'b0;   bus.product = '0;
    bus.prod_signed = 1'b0;   bus.out_ready = 1'b0;
    bus18.clear = 1'b0; bus18.in_valid = 1'b0; bus18.product = '0;
    bus18.prod_signed = 1'b0; bus18.out_ready = 1'b0;
    bus1.clear = 1'b0;  bus1.in_valid = 1'b0;  bus1.product = '0;
    bus1.prod_signed = 1'b0;  bus1.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkMain("reset", 1'b0, 24'h0, 1'b0, 8'd0);

    // Mixed signedness: 50 - 100 + 65436 + 7 = 65393 = 0xFF71.
    applyStimulus(16'h0032, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'hFF9C, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'hFF9C, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0007, 1'b1, 1'b1, 1'b0, 1'b0);

    // Backpressure: offered products are ignored while the result waits.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
      checkMain("hold", 1'b1, 24'h00FF71, 1'b0, 8'd4);
    end
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMain("release", 1'b0, 24'h0, 1'b0, 8'd0);

    // clear mid-block with a product offered in the same cycle.
    applyStimulus(16'h0005, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0003, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0009, 1'b0, 1'b1, 1'b0, 1'b1);
    checkMain("pre_clear", 1'b0, 24'h8, 1'b0, 8'd2);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMain("clear", 1'b0, 24'h0, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMain("after_clear", 1'b1, 24'h4, 1'b0, 8'd4);

    // clear together with the output handshake.
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMain("clear_and_take", 1'b0, 24'h0, 1'b0, 8'd0);

    // Overflow on the AW=18 instance: 4 x 0xFFFF unsigned.
    @(negedge clk);
    bus18.product = 16'hFFFF; bus18.prod_signed = 1'b0; bus18.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("ovf18.overflow", 32'(bus18.overflow), (i >= 3) ? 32'd1 : 32'd0);
      checkOutput("ovf18.count", 32'(bus18.count), 32'(i));
    end
    checkOutput("ovf18.acc_out", 32'(bus18.acc_out), 32'h3FFFC);
    checkOutput("ovf18.out_valid", 32'(bus18.out_valid), 32'd1);
    bus18.in_valid = 1'b0; bus18.out_ready = 1'b1;
    @(negedge clk);
    bus18.out_ready = 1'b0;
    checkOutput("ovf18.released_ovf", 32'(bus18.overflow), 32'd0);
    checkOutput("ovf18.released_acc", 32'(bus18.acc_out), 32'd0);

    // N=1 streaming of -100 with the consumer always ready.
    @(negedge clk);
    bus1.product = 16'hFF9C; bus1.prod_signed = 1'b1; bus1.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("n1.out_valid", 32'(bus1.out_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) begin
        checkOutput("n1.acc_out", 32'(bus1.acc_out), 32'hFFFF9C);
      end
    end
    bus1.in_valid = 1'b0;

    // Asynchronous reset while the main instance sits in DONE.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h0010, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMain("pre_rst", 1'b1, 24'h40, 1'b0, 8'd4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkMain("async_rst", 1'b0, 24'h0, 1'b0, 8'd0);
    #1 rst = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMain("post_rst", 1'b0, 24'h0, 1'b0, 8'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
